axi_burst_mem_slave: RTL and testbench

- Parametrised memory-mapped slave with independent read and write channels. Each channel has its own VALID/READY handshakes and its own ID, burst length and burst-type fields.
- Fronts an on-chip word array for the bus master.
- Successor to the single-address-bus 8-bit slave. Adds generic widths and depth, and FIXED/INCR/WRAP bursts.
- Read and write channels run concurrently. The block returns explicit error responses.

---
 rtl/axi_mem_pkg.sv | 27 ++
 rtl/burst_addr_gen.sv | 35 +++
 rtl/axi_burst_mem_slave.sv | 218 +++++++++++++++++++++
 tb/tb_axi_burst_mem_slave.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_pkg.sv
// Shared constants, state encodings and helpers for the burst memory slave.
package axi_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    // WRAP bursts need a power-of-two beat count between 2 and 16.
    function automatic logic wrap_legal(input int unsigned len);
        return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
    endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts; one instance per channel.
module burst_addr_gen
    import axi_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 4
) (
    input  logic [ADDR_W-1:0] start,
    input  logic [LEN_W-1:0]  len,
    input  logic [1:0]        burst,
    input  logic [ADDR_W-1:0] cur,
    output logic [ADDR_W-1:0] next_addr_c,
    output logic              wrap_illegal_c
);

    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] incr;

    // For a legal WRAP, len is 2^k-1, so it doubles as the in-window offset mask.
    assign mask = ADDR_W'(len);
    assign base = start & ~mask;
    assign incr = cur + ADDR_W'(1);

    always_comb begin
        wrap_illegal_c = (burst == BURST_WRAP) && !wrap_legal(32'(len));
        next_addr_c    = incr;
        if (burst == BURST_FIXED) begin
            next_addr_c = cur;
        end else if ((burst == BURST_WRAP) && !wrap_illegal_c) begin
            next_addr_c = base | (incr & mask);
        end
    end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// Burst memory slave: independent read and write channels over one word array.
module axi_burst_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ARVALID,
    output logic              ARREADY,
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [LEN_W-1:0]  ARLEN,
    input  logic [1:0]        ARBURST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [ID_W-1:0]   RID,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ID_W-1:0]   AWID,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [LEN_W-1:0]  AWLEN,
    input  logic [1:0]        AWBURST,
    input  logic              WVALID,
    output logic              WREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WLAST,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP
);

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    // ---------------- read channel ----------------
    r_state_t          r_state, r_state_nxt;
    logic [ADDR_W-1:0] r_addr, r_start, r_addr_nxt_c, r_fetch_addr;
    logic [LEN_W-1:0]  r_len, r_beat;
    logic [1:0]        r_burst;
    logic              r_wrap_bad_c, r_load, r_fetch_last, r_fetch_bad;
    logic              ar_hs, r_hs;

    assign ar_hs = ARVALID && ARREADY;
    assign r_hs  = RVALID && RREADY;

    burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_r_gen (
        .start(r_start), .len(r_len), .burst(r_burst), .cur(r_addr),
        .next_addr_c(r_addr_nxt_c), .wrap_illegal_c(r_wrap_bad_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= R_IDLE;
        else      r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && RLAST) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Selects which beat gets fetched into the registered R outputs.
    always_comb begin
        r_load       = 1'b0;
        r_fetch_addr = r_addr;
        r_fetch_last = 1'b0;
        r_fetch_bad  = r_wrap_bad_c;
        case (r_state)
            R_IDLE: if (ar_hs) begin
                r_load       = 1'b1;
                r_fetch_addr = ARADDR;
                r_fetch_last = (ARLEN == '0);
                r_fetch_bad  = (ARBURST == BURST_WRAP) && !wrap_legal(32'(ARLEN));
            end
            R_DATA: if (r_hs && !RLAST) begin
                r_load       = 1'b1;
                r_fetch_addr = r_addr_nxt_c;
                r_fetch_last = ((r_beat + LEN_W'(1)) == r_len);
            end
            default: r_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RID     <= '0;
            RRESP   <= RESP_OKAY;
            RLAST   <= 1'b0;
            r_addr  <= '0;
            r_start <= '0;
            r_len   <= '0;
            r_burst <= BURST_FIXED;
            r_beat  <= '0;
        end else begin
            ARREADY <= (r_state_nxt == R_IDLE);
            RVALID  <= (r_state_nxt == R_DATA);
            if (ar_hs) begin
                RID     <= ARID;
                r_start <= ARADDR;
                r_len   <= ARLEN;
                r_burst <= ARBURST;
                r_beat  <= '0;
            end else if (r_hs && !RLAST) begin
                r_beat <= r_beat + LEN_W'(1);
            end
            if (r_load) begin
                r_addr <= r_fetch_addr;
                RDATA  <= in_range(r_fetch_addr) ? mem[r_fetch_addr] : '0;
                RRESP  <= (r_fetch_bad || !in_range(r_fetch_addr)) ? RESP_SLVERR : RESP_OKAY;
                RLAST  <= r_fetch_last;
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_t          w_state, w_state_nxt;
    logic [ADDR_W-1:0] w_addr, w_start, w_addr_nxt_c;
    logic [LEN_W-1:0]  w_len, w_beat;
    logic [1:0]        w_burst;
    logic [ID_W-1:0]   w_id;
    logic              w_wrap_bad_c, w_err, w_err_set, w_err_nxt, w_we;
    logic              aw_hs, w_hs, b_hs, w_at_last;

    assign aw_hs     = AWVALID && AWREADY;
    assign w_hs      = WVALID && WREADY;
    assign b_hs      = BVALID && BREADY;
    assign w_at_last = (w_beat == w_len);

    burst_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_w_gen (
        .start(w_start), .len(w_len), .burst(w_burst), .cur(w_addr),
        .next_addr_c(w_addr_nxt_c), .wrap_illegal_c(w_wrap_bad_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) w_state <= W_IDLE;
        else      w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && w_at_last) w_state_nxt = W_RESP;
            W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Sticky error collects range, illegal-wrap and WLAST-placement faults.
    always_comb begin
        w_err_set = 1'b0;
        if (w_hs) begin
            if (!in_range(w_addr) || w_wrap_bad_c) w_err_set = 1'b1;
            if (WLAST != w_at_last)                w_err_set = 1'b1;
        end
        w_err_nxt = aw_hs ? 1'b0 : (w_err || w_err_set);
        w_we      = w_hs && in_range(w_addr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= RESP_OKAY;
            w_err   <= 1'b0;
            w_id    <= '0;
            w_start <= '0;
            w_len   <= '0;
            w_burst <= BURST_FIXED;
            w_addr  <= '0;
            w_beat  <= '0;
        end else begin
            AWREADY <= (w_state_nxt == W_IDLE);
            WREADY  <= (w_state_nxt == W_DATA);
            BVALID  <= (w_state_nxt == W_RESP);
            BID     <= (w_state_nxt == W_RESP) ? w_id : '0;
            BRESP   <= ((w_state_nxt == W_RESP) && w_err_nxt) ? RESP_SLVERR : RESP_OKAY;
            w_err   <= w_err_nxt;
            if (aw_hs) begin
                w_id    <= AWID;
                w_start <= AWADDR;
                w_len   <= AWLEN;
                w_burst <= AWBURST;
                w_addr  <= AWADDR;
                w_beat  <= '0;
            end else if (w_hs) begin
                w_addr <= w_addr_nxt_c;
                w_beat <= w_beat + LEN_W'(1);
            end
        end
    end

    // Array has no reset; the read port samples it in the same edge, giving read-first.
    always_ff @(posedge clk) begin
        if (w_we) mem[w_addr] <= WDATA;
    end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Randomized self-checking bench for axi_burst_mem_slave against a burst-level memory model.
module tb_axi_burst_mem_slave;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 200;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ARVALID, ARREADY;
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic [1:0]        ARBURST;
    logic              RVALID, RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [ID_W-1:0]   RID;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              AWVALID, AWREADY;
    logic [ID_W-1:0]   AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [LEN_W-1:0]  AWLEN;
    logic [1:0]        AWBURST;
    logic              WVALID, WREADY;
    logic [DATA_W-1:0] WDATA;
    logic              WLAST;
    logic              BVALID, BREADY;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;

    always #5 clk = ~clk;

    axi_burst_mem_slave #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ID_W(ID_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARADDR(ARADDR),
        .ARLEN(ARLEN), .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RID(RID),
        .RRESP(RRESP), .RLAST(RLAST),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR),
        .AWLEN(AWLEN), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model_mem [256];
    bit         known     [256];
    logic [7:0] wbuf      [16];

    // Address of beat i, straight from the burst rules.
    function automatic logic [7:0] beat_addr(input logic [7:0] start, input int len,
                                             input logic [1:0] burst, input int i);
        int n;
        int base;
        n = len + 1;
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && (n == 2 || n == 4 || n == 8 || n == 16)) begin
            base = (int'(start) / n) * n;
            return 8'(base + ((int'(start) - base + i) % n));
        end
        return 8'(int'(start) + i);
    endfunction

    function automatic bit wrap_bad(input int len, input logic [1:0] burst);
        return burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15);
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [7:0] addr, input int len,
                            input logic [1:0] burst, input int wlast_at, input int bdelay,
                            input string tag);
        bit         err;
        int         cyc;
        logic [7:0] a;
        logic [1:0] exp_resp;
        err = wrap_bad(len, burst);
        AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = 4'(len); AWBURST = burst;
        cyc = 0;
        while (!AWREADY && cyc < 50) begin @(posedge clk); #1; cyc++; end
        if (!AWREADY) begin
            n_tests++; n_fail++;
            $display("FAIL %s aw_handshake: AWREADY never rose", tag);
            AWVALID = 1'b0;
            return;
        end
        @(posedge clk); #1;
        AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            WVALID = 1'b1; WDATA = wbuf[i]; WLAST = (i == wlast_at);
            cyc = 0;
            while (!WREADY && cyc < 50) begin @(posedge clk); #1; cyc++; end
            if (!WREADY) begin
                n_tests++; n_fail++;
                $display("FAIL %s w_handshake: WREADY low at beat %0d", tag, i);
                WVALID = 1'b0;
                return;
            end
            @(posedge clk); #1;
            a = beat_addr(addr, len, burst, i);
            if (32'(a) < DEPTH) begin
                model_mem[a] = wbuf[i];
                known[a]     = !wrap_bad(len, burst);
            end else begin
                err = 1'b1;
            end
            if ((i == wlast_at) != (i == len)) err = 1'b1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        exp_resp = err ? 2'b10 : 2'b00;
        cyc = 0;
        while (!BVALID && cyc < 50) begin @(posedge clk); #1; cyc++; end
        for (int k = 0; k < bdelay; k++) begin
            n_tests++;
            if ({BVALID, BID, BRESP} !== {1'b1, id, exp_resp}) begin
                n_fail++;
                $display("FAIL %s b_hold: got valid=%b id=%h resp=%b, want 1 %h %b",
                         tag, BVALID, BID, BRESP, id, exp_resp);
            end
            @(posedge clk); #1;
        end
        BREADY = 1'b1;
        n_tests++;
        if ({BVALID, BID, BRESP} !== {1'b1, id, exp_resp}) begin
            n_fail++;
            $display("FAIL %s b_resp: got valid=%b id=%h resp=%b, want 1 %h %b",
                     tag, BVALID, BID, BRESP, id, exp_resp);
        end
        @(posedge clk); #1;
        BREADY = 1'b0;
        n_tests++;
        if ({BVALID, AWREADY} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s b_done: got bvalid=%b awready=%b, want 0 1", tag, BVALID, AWREADY);
        end
    endtask

    // rmode: 0 always ready, 1 random ready, 2 ready pattern 1,0,0,1.
    task automatic do_read(input logic [3:0] id, input logic [7:0] addr, input int len,
                           input logic [1:0] burst, input int rmode, input string tag);
        int         beat, cyc, pc;
        logic [7:0] a, edata;
        logic [1:0] eresp;
        bit         skip;
        ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = 4'(len); ARBURST = burst;
        RREADY = 1'b0;
        cyc = 0;
        while (!ARREADY && cyc < 50) begin @(posedge clk); #1; cyc++; end
        n_tests++;
        if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ar_accept: got arready=%b rvalid=%b, want 1 0", tag, ARREADY, RVALID);
            ARVALID = 1'b0;
            return;
        end
        @(posedge clk); #1;
        ARVALID = 1'b0;
        n_tests++;
        if (RVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL %s r_latency: RVALID=%b one cycle after AR, want 1", tag, RVALID);
        end
        beat = 0; cyc = 0; pc = 0;
        while (beat <= len && cyc < 200) begin
            a     = beat_addr(addr, len, burst, beat);
            edata = (32'(a) < DEPTH) ? model_mem[a] : 8'h00;
            eresp = (32'(a) >= DEPTH || wrap_bad(len, burst)) ? 2'b10 : 2'b00;
            skip  = wrap_bad(len, burst) || (32'(a) < DEPTH && !known[a]);
            n_tests++;
            if ({RVALID, skip ? 8'h00 : RDATA, RID, RRESP, RLAST} !==
                {1'b1, skip ? 8'h00 : edata, id, eresp, beat == len}) begin
                n_fail++;
                $display("FAIL %s r_beat%0d @%h: got v=%b d=%h id=%h resp=%b last=%b, want 1 %h %h %b %b",
                         tag, beat, a, RVALID, RDATA, RID, RRESP, RLAST, edata, id, eresp, beat == len);
            end
            case (rmode)
                0:       RREADY = 1'b1;
                1:       RREADY = 1'($urandom_range(0, 1));
                default: RREADY = (pc % 4 == 0) || (pc % 4 == 3);
            endcase
            pc++;
            @(posedge clk); #1;
            if (RREADY) beat++;
            cyc++;
        end
        RREADY = 1'b0;
        n_tests++;
        if (beat <= len || {RVALID, ARREADY} !== 2'b01) begin
            n_fail++;
            $display("FAIL %s r_done: got beats=%0d rvalid=%b arready=%b, want %0d 0 1",
                     tag, beat, RVALID, ARREADY, len + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ARVALID = 0; ARID = 0; ARADDR = 0; ARLEN = 0; ARBURST = 0; RREADY = 0;
        AWVALID = 0; AWID = 0; AWADDR = 0; AWLEN = 0; AWBURST = 0;
        WVALID = 0; WDATA = 0; WLAST = 0; BREADY = 0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({ARREADY, RVALID, RDATA, RID, RRESP, RLAST, AWREADY, WREADY, BVALID, BID, BRESP} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ar=%b rv=%b aw=%b w=%b b=%b, want all 0",
                     ARREADY, RVALID, AWREADY, WREADY, BVALID);
        end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({ARREADY, AWREADY, RVALID, WREADY, BVALID} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_release: got ar=%b aw=%b rv=%b w=%b b=%b, want 1 1 0 0 0",
                     ARREADY, AWREADY, RVALID, WREADY, BVALID);
        end
    endtask

    task automatic test_fill();
        int len;
        for (int b = 0; b < int'(DEPTH); b += 16) begin
            len = (int'(DEPTH) - 1 - b < 15) ? int'(DEPTH) - 1 - b : 15;
            for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
            do_write(4'(b / 16), 8'(b), len, 2'b01, len, 0, "fill");
        end
    endtask

    task automatic test_incr_read();
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'h11 + i);
        do_write(4'd3, 8'h10, 3, 2'b01, 3, 0, "incr_wr");
        do_read(4'd5, 8'h10, 3, 2'b01, 0, "incr_rd");
        do_read(4'd7, 8'h12, 0, 2'b00, 0, "single_rd");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) wbuf[i] = 8'(8'hA0 + i);
        do_write(4'd9, 8'h06, 3, 2'b10, 3, 0, "wrap_wr");
        do_read(4'd1, 8'h04, 3, 2'b01, 0, "wrap_chk");
        do_read(4'd2, 8'h07, 3, 2'b10, 0, "wrap_rd");
        do_read(4'd4, 8'h20, 2, 2'b10, 0, "wrap_bad_rd");
        for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
        do_write(4'd6, 8'h30, 2, 2'b10, 2, 0, "wrap_bad_wr");
    endtask

    task automatic test_range();
        do_read(4'd2, 8'hC6, 3, 2'b01, 0, "range_rd");
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        do_write(4'd8, 8'hC6, 3, 2'b01, 3, 0, "range_wr");
        do_read(4'd3, 8'hC6, 3, 2'b01, 0, "range_rd2");
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
        do_write(4'd11, 8'h50, 7, 2'b01, 7, 5, "bp_wr");
        do_read(4'd12, 8'h50, 7, 2'b01, 2, "bp_rd");
        do_read(4'd13, 8'h52, 3, 2'b10, 1, "bp_rd_wrap");
    endtask

    task automatic test_wlast();
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        do_write(4'd14, 8'h60, 3, 2'b01, 1, 0, "wlast_early");
        do_read(4'd14, 8'h60, 3, 2'b01, 0, "wlast_rd");
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        do_write(4'd15, 8'h64, 3, 2'b01, 99, 1, "wlast_missing");
    endtask

    task automatic test_concurrent();
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
        fork
            do_write(4'd1, 8'h40, 7, 2'b01, 7, 2, "conc_wr");
            do_read(4'd2, 8'h80, 7, 2'b01, 1, "conc_rd");
        join
        do_read(4'd3, 8'h40, 7, 2'b01, 0, "conc_chk");
    endtask

    task automatic test_random();
        logic [1:0] burst;
        logic [7:0] addr;
        logic [3:0] id;
        int         len, wl;
        for (int t = 0; t < 40; t++) begin
            burst = 2'($urandom_range(0, 2));
            len   = $urandom_range(0, 15);
            addr  = 8'($urandom);
            id    = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
                wl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : len;
                do_write(id, addr, len, burst, wl, $urandom_range(0, 3), "rand_wr");
            end else begin
                do_read(id, addr, len, burst, $urandom_range(0, 2), "rand_rd");
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        ARVALID = 1'b1; ARID = 4'd10; ARADDR = 8'h10; ARLEN = 4'd3; ARBURST = 2'b01;
        cyc = 0;
        while (!ARREADY && cyc < 50) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        ARVALID = 1'b0;
        RREADY = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        RREADY = 1'b0;
        n_tests++;
        if (RVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_setup: RVALID=%b before reset, want 1", RVALID);
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({ARREADY, RVALID, RDATA, RID, RRESP, RLAST, AWREADY, WREADY, BVALID, BID, BRESP} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got rv=%b d=%h id=%h last=%b ar=%b, want all 0",
                     RVALID, RDATA, RID, RLAST, ARREADY);
        end
        #2 rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({ARREADY, RVALID} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid_release: got arready=%b rvalid=%b, want 1 0", ARREADY, RVALID);
        end
        do_read(4'd5, 8'h10, 3, 2'b01, 0, "after_reset_rd");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 8'h00;
            known[i]     = 1'b0;
        end
        test_reset();
        test_fill();
        test_incr_read();
        test_wrap();
        test_range();
        test_backpressure();
        test_wlast();
        test_concurrent();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
